// File: rtl/stack_sequencer.sv
// Multi-cycle push/pop/call/ret sequencer: owns the stack pointer, drives the
// single-port data memory and stalls the pipeline until each stack op retires.
module stack_sequencer #(
  parameter int                DATA_W     = 16,
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] STACK_TOP  = 8'hFF,
  parameter logic [ADDR_W-1:0] STACK_BASE = 8'hC0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              op_valid_i,
  input  logic              op_push_i,
  input  logic              op_pop_i,
  input  logic              op_call_i,
  input  logic              op_ret_i,
  input  logic [DATA_W-1:0] reg_rdata_i,
  input  logic [DATA_W-1:0] pc_ret_i,
  input  logic [DATA_W-1:0] call_target_i,
  output logic              stall_o,
  output logic              done_o,
  output logic              reg_wr_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  output logic              pc_load_o,
  output logic [DATA_W-1:0] pc_target_o,
  output logic [ADDR_W-1:0] sp_o,
  output logic              err_ovf_o,
  output logic              err_unf_o,
  output logic              err_ill_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  // states: IDLE accept op | WR write req | RD read req | RWAIT await rdata | DONE retire pulse
  typedef enum logic [2:0] {IDLE, WR, RD, RWAIT, DONE} state_e;
  typedef enum logic [1:0] {K_PUSH, K_POP, K_CALL, K_RET} kind_e;

  localparam logic [ADDR_W-1:0] SP_ONE = 1;

  state_e            state_q, state_d;
  kind_e             kind_q, kind_d;
  logic              ok_q, ok_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] call_tgt_q, call_tgt_d;
  logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
  logic [DATA_W-1:0] pc_target_q, pc_target_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_unf_q, err_unf_d;
  logic              err_ill_q, err_ill_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      kind_q      <= K_PUSH;
      ok_q        <= 1'b0;
      sp_q        <= STACK_TOP;
      addr_q      <= '0;
      wdata_q     <= '0;
      call_tgt_q  <= '0;
      reg_wdata_q <= '0;
      pc_target_q <= '0;
      err_ovf_q   <= 1'b0;
      err_unf_q   <= 1'b0;
      err_ill_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      ok_q        <= ok_d;
      sp_q        <= sp_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      call_tgt_q  <= call_tgt_d;
      reg_wdata_q <= reg_wdata_d;
      pc_target_q <= pc_target_d;
      err_ovf_q   <= err_ovf_d;
      err_unf_q   <= err_unf_d;
      err_ill_q   <= err_ill_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    ok_d        = ok_q;
    sp_d        = sp_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    call_tgt_d  = call_tgt_q;
    reg_wdata_d = reg_wdata_q;
    pc_target_d = pc_target_q;
    err_ovf_d   = err_ovf_q;
    err_unf_d   = err_unf_q;
    err_ill_d   = err_ill_q;
    done_o      = 1'b0;
    reg_wr_o    = 1'b0;
    pc_load_o   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (op_valid_i) begin
          state_d = DONE;
          ok_d    = 1'b0;
          case ({op_push_i, op_pop_i, op_call_i, op_ret_i})
            4'b1000, 4'b0010: begin
              kind_d     = op_push_i ? K_PUSH : K_CALL;
              call_tgt_d = call_target_i;
              if (sp_q == STACK_BASE) begin
                err_ovf_d = 1'b1;
              end else begin
                ok_d    = 1'b1;
                addr_d  = sp_q - SP_ONE;
                wdata_d = op_push_i ? reg_rdata_i : pc_ret_i;
                state_d = WR;
              end
            end
            4'b0100, 4'b0001: begin
              kind_d = op_pop_i ? K_POP : K_RET;
              if (sp_q == STACK_TOP) begin
                err_unf_d = 1'b1;
              end else begin
                ok_d    = 1'b1;
                addr_d  = sp_q;
                state_d = RD;
              end
            end
            default: err_ill_d = 1'b1;
          endcase
        end
      end
      WR: begin
        if (mem_gnt_i) begin
          sp_d = sp_q - SP_ONE;
          if (kind_q == K_CALL) pc_target_d = call_tgt_q;
          state_d = DONE;
        end
      end
      RD: begin
        if (mem_gnt_i) state_d = RWAIT;
      end
      RWAIT: begin
        if (mem_rvalid_i) begin
          if (kind_q == K_POP) reg_wdata_d = mem_rdata_i;
          else                 pc_target_d = mem_rdata_i;
          sp_d    = sp_q + SP_ONE;
          state_d = DONE;
        end
      end
      DONE: begin
        done_o    = 1'b1;
        reg_wr_o  = ok_q && (kind_q == K_POP);
        pc_load_o = ok_q && ((kind_q == K_CALL) || (kind_q == K_RET));
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // DONE releases the pipeline so the next op can be presented right after done
  assign stall_o     = (state_q == IDLE) ? op_valid_i : (state_q != DONE);
  assign mem_req_o   = (state_q == WR) || (state_q == RD);
  assign mem_we_o    = (state_q == WR);
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign sp_o        = sp_q;
  assign reg_wdata_o = reg_wdata_q;
  assign pc_target_o = pc_target_q;
  assign err_ovf_o   = err_ovf_q;
  assign err_unf_o   = err_unf_q;
  assign err_ill_o   = err_ill_q;

endmodule
